// File: rtl/vga_pkg.sv
// XGA raster timing constants shared by the timing generator and its axis counters.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_pkg;

    localparam int unsigned COUNT_W = 12;

    // Horizontal timing in pixels
    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned H_FP     = 24;
    localparam int unsigned H_SYNC   = 136;
    localparam int unsigned H_BP     = 160;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int unsigned V_ACTIVE = 768;
    localparam int unsigned V_FP     = 3;
    localparam int unsigned V_SYNC   = 6;
    localparam int unsigned V_BP     = 29;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows: start inclusive, end exclusive
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: next-count, wrap and blank/sync decodes of the next count.
// Latency: purely combinational; the parent holds the count register.
// Backpressure: tick low holds the count (next equals current), no wrap.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE,
    parameter int unsigned FP     = H_FP,
    parameter int unsigned SYNC   = H_SYNC,
    parameter int unsigned BP     = H_BP
) (
    input  logic               tick,
    input  logic [COUNT_W-1:0] cnt_cur,
    output logic [COUNT_W-1:0] cnt_nxt,
    output logic               wrap,
    output logic               blank,
    output logic               sync
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    // Every boundary must fit the 12-bit counter, otherwise decodes alias.
    if (TOTAL >= (1 << COUNT_W)) begin : g_bad_params
        $error("vga_axis_counter: ACTIVE+FP+SYNC+BP must be below 2**COUNT_W");
    end

    localparam logic [COUNT_W-1:0] LAST_C       = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] ACTIVE_C     = COUNT_W'(ACTIVE);
    localparam logic [COUNT_W-1:0] SYNC_START_C = COUNT_W'(ACTIVE + FP);
    localparam logic [COUNT_W-1:0] SYNC_END_C   = COUNT_W'(ACTIVE + FP + SYNC);

    // Advance/wrap the count and decode the value it will take after this edge.
    always_comb begin
        wrap    = tick && (cnt_cur == LAST_C);
        cnt_nxt = cnt_cur;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (tick) begin
            cnt_nxt = cnt_cur + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
        blank = (cnt_nxt >= ACTIVE_C);
        sync  = (cnt_nxt >= SYNC_START_C) && (cnt_nxt < SYNC_END_C);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// XGA raster timing source: counters, blank/sync decodes and a frame-start strobe.
// Latency: one register stage; every output reflects the same position in the same cycle.
// Backpressure: en low freezes all outputs, including a frame_start pulse already high.
module vga_timing_gen
    import vga_pkg::COUNT_W;
#(
    parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP        = vga_pkg::H_FP,
    parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP        = vga_pkg::V_FP,
    parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_pkg::V_BP,
    parameter logic        SYNC_ACTIVE = 1'b1
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               en,
    output logic [COUNT_W-1:0] hcount_out,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               hblnk_out,
    output logic               vblnk_out,
    output logic               frame_start
);

    logic [COUNT_W-1:0] h_nxt, v_nxt;
    logic               h_wrap, v_wrap, v_tick;
    logic               h_blank, v_blank, h_sync, v_sync;

    logic [COUNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               hblnk_q, hblnk_d, vblnk_q, vblnk_d;
    logic               frame_start_q, frame_start_d;

    // Lines advance only on the cycle the pixel counter wraps.
    assign v_tick = en & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .tick    (en),
        .cnt_cur (hcount_q),
        .cnt_nxt (h_nxt),
        .wrap    (h_wrap),
        .blank   (h_blank),
        .sync    (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .tick    (v_tick),
        .cnt_cur (vcount_q),
        .cnt_nxt (v_nxt),
        .wrap    (v_wrap),
        .blank   (v_blank),
        .sync    (v_sync)
    );

    // Next register values; with en low the counters hold, and the strobe keeps its level.
    always_comb begin
        hcount_d      = h_nxt;
        vcount_d      = v_nxt;
        hblnk_d       = h_blank;
        vblnk_d       = v_blank;
        hsync_d       = h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d       = v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        frame_start_d = frame_start_q;
        if (en) begin
            frame_start_d = v_wrap;
        end
    end

    // Output registers; reset lands on (0,0) with syncs idle and no strobe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount_out  = hcount_q;
    assign vcount_out  = vcount_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign hblnk_out   = hblnk_q;
    assign vblnk_out   = vblnk_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: an XGA instance and a shrunken-raster instance (active-low syncs).
// Latency: expectations are queued before each edge and popped one cycle later.
// Backpressure: exercised through the en stall scenarios.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] hc;
        logic [11:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;

    logic [11:0] hc_x, vc_x, hc_s, vc_s;
    logic        hs_x, vs_x, hb_x, vb_x, fs_x;
    logic        hs_s, vs_s, hb_s, vb_s, fs_s;

    exp_t        obs_x, obs_s, exp_x, exp_s;
    exp_t        q_x[$];
    exp_t        q_s[$];

    int          checks   = 0;
    int          failures = 0;

    // Reference positions: mx_* for the XGA raster (1344x806), ms_* for the small one (32x21)
    logic [11:0] mx_h = 12'd0, mx_v = 12'd0, ms_h = 12'd0, ms_v = 12'd0;
    logic        mx_f = 1'b0, ms_f = 1'b0;

    always #5 clk_in = ~clk_in;

    vga_timing_gen dut_x (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .hcount_out  (hc_x),
        .vcount_out  (vc_x),
        .hsync_out   (hs_x),
        .vsync_out   (vs_x),
        .hblnk_out   (hb_x),
        .vblnk_out   (vb_x),
        .frame_start (fs_x)
    );

    vga_timing_gen #(
        .H_ACTIVE (20), .H_FP (3), .H_SYNC (4), .H_BP (5),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (3), .V_BP (4),
        .SYNC_ACTIVE (1'b0)
    ) dut_s (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .hcount_out  (hc_s),
        .vcount_out  (vc_s),
        .hsync_out   (hs_s),
        .vsync_out   (vs_s),
        .hblnk_out   (hb_s),
        .vblnk_out   (vb_s),
        .frame_start (fs_s)
    );

    assign obs_x = {hc_x, vc_x, hs_x, vs_x, hb_x, vb_x, fs_x};
    assign obs_s = {hc_s, vc_s, hs_s, vs_s, hb_s, vb_s, fs_s};

    function automatic exp_t xga_exp(input logic [11:0] h, input logic [11:0] v, input logic f);
        exp_t e;
        e.hc = h;
        e.vc = v;
        e.hb = (h >= 12'd1024);
        e.hs = (h >= 12'd1048) && (h <= 12'd1183);
        e.vb = (v >= 12'd768);
        e.vs = (v >= 12'd771) && (v <= 12'd776);
        e.fs = f;
        return e;
    endfunction

    // Small raster: blank from 20 / 12, sync windows 23..26 / 14..16, syncs active low
    function automatic exp_t sml_exp(input logic [11:0] h, input logic [11:0] v, input logic f);
        exp_t e;
        e.hc = h;
        e.vc = v;
        e.hb = (h >= 12'd20);
        e.hs = !((h >= 12'd23) && (h <= 12'd26));
        e.vb = (v >= 12'd12);
        e.vs = !((v >= 12'd14) && (v <= 12'd16));
        e.fs = f;
        return e;
    endfunction

    // Drive en for one edge, queue the expected outputs, then pop them once the edge has happened.
    task automatic advance(input logic en_v);
        @(negedge clk_in);
        en = en_v;
        if (en_v && rst_n) begin
            mx_f = (mx_h == 12'd1343) && (mx_v == 12'd805);
            if (mx_h == 12'd1343) begin
                mx_h = 12'd0;
                mx_v = (mx_v == 12'd805) ? 12'd0 : mx_v + 12'd1;
            end else begin
                mx_h = mx_h + 12'd1;
            end
            ms_f = (ms_h == 12'd31) && (ms_v == 12'd20);
            if (ms_h == 12'd31) begin
                ms_h = 12'd0;
                ms_v = (ms_v == 12'd20) ? 12'd0 : ms_v + 12'd1;
            end else begin
                ms_h = ms_h + 12'd1;
            end
        end
        q_x.push_back(xga_exp(mx_h, mx_v, mx_f));
        q_s.push_back(sml_exp(ms_h, ms_v, ms_f));
        @(posedge clk_in);
        #1;
        exp_x = q_x.pop_front();
        exp_s = q_s.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            advance(1'b0);
            checks++;
            if (obs_x !== exp_x) begin
                failures++;
                $display("FAIL reset_x: got %h required %h", obs_x, exp_x);
            end
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL reset_s: got %h required %h", obs_s, exp_s);
            end
        end
        checks++;
        if (hs_x !== 1'b0 || vs_x !== 1'b0 || hs_s !== 1'b1 || vs_s !== 1'b1) begin
            failures++;
            $display("FAIL reset_sync_idle: got x=%b%b s=%b%b required x=00 s=11", hs_x, vs_x, hs_s, vs_s);
        end
        rst_n = 1'b1;
        advance(1'b1);
        checks++;
        if (hc_x !== 12'd1 || vc_x !== 12'd0 || fs_x !== 1'b0) begin
            failures++;
            $display("FAIL release_first_edge: got h=%0d v=%0d fs=%b required h=1 v=0 fs=0", hc_x, vc_x, fs_x);
        end
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL release_s: got %h required %h", obs_s, exp_s);
        end
    endtask

    task automatic test_hline();
        int hb_n = 0;
        int hs_n = 0;
        for (int i = 0; i < 1343; i++) begin
            advance(1'b1);
            checks++;
            if (obs_x !== exp_x) begin
                failures++;
                $display("FAIL hline_x: got %h required %h", obs_x, exp_x);
            end
            if (hb_x === 1'b1) hb_n++;
            if (hs_x === 1'b1) hs_n++;
        end
        checks++;
        if (hb_n != 320) begin
            failures++;
            $display("FAIL hline_blank_cycles: got %0d required 320", hb_n);
        end
        checks++;
        if (hs_n != 136) begin
            failures++;
            $display("FAIL hline_sync_cycles: got %0d required 136", hs_n);
        end
        checks++;
        if (hc_x !== 12'd0 || vc_x !== 12'd1) begin
            failures++;
            $display("FAIL hline_wrap: got (%0d,%0d) required (0,1)", hc_x, vc_x);
        end
    endtask

    task automatic test_vertical();
        int   vs_n = 0;
        int   vb_n = 0;
        logic prev_vb;
        prev_vb = vb_s;
        for (int i = 0; i < 672; i++) begin
            advance(1'b1);
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL vert_s: got %h required %h", obs_s, exp_s);
            end
            if (vs_s === 1'b0) vs_n++;
            if (vb_s === 1'b1) vb_n++;
            if (prev_vb === 1'b0 && vb_s === 1'b1) begin
                checks++;
                if (vc_s !== 12'd12 || hc_s !== 12'd0) begin
                    failures++;
                    $display("FAIL vblank_rise: got (%0d,%0d) required (0,12)", hc_s, vc_s);
                end
            end
            prev_vb = vb_s;
        end
        checks++;
        if (vs_n != 96) begin
            failures++;
            $display("FAIL vsync_cycles: got %0d required 96", vs_n);
        end
        checks++;
        if (vb_n != 288) begin
            failures++;
            $display("FAIL vblank_cycles: got %0d required 288", vb_n);
        end
    endtask

    task automatic test_frame_wrap();
        int n = 0;
        while (!(ms_h == 12'd31 && ms_v == 12'd20) && n < 1000) begin
            advance(1'b1);
            n++;
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL wrap_approach: got %h required %h", obs_s, exp_s);
            end
        end
        if (n >= 1000) begin
            checks++;
            failures++;
            $display("FAIL wrap_approach_timeout: got %0d cycles required <1000", n);
        end
        advance(1'b1);
        checks++;
        if (hc_s !== 12'd0 || vc_s !== 12'd0 || fs_s !== 1'b1 || hb_s !== 1'b0 || vb_s !== 1'b0) begin
            failures++;
            $display("FAIL frame_wrap: got h=%0d v=%0d fs=%b hb=%b vb=%b required 0 0 1 0 0",
                     hc_s, vc_s, fs_s, hb_s, vb_s);
        end
        n = 0;
        do begin
            advance(1'b1);
            n++;
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL frame_period_s: got %h required %h", obs_s, exp_s);
            end
        end while (fs_s !== 1'b1 && n < 2000);
        checks++;
        if (n != 672) begin
            failures++;
            $display("FAIL frame_period: got %0d cycles required 672", n);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        while (!(ms_h == 12'd31 && ms_v == 12'd20) && n < 1000) begin
            advance(1'b1);
            n++;
        end
        checks++;
        if (n >= 1000 || obs_s !== exp_s) begin
            failures++;
            $display("FAIL stall_approach: got %h required %h", obs_s, exp_s);
        end
        for (int i = 0; i < 10; i++) begin
            advance(1'b0);
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL stall_hold_s: got %h required %h", obs_s, exp_s);
            end
            checks++;
            if (obs_x !== exp_x) begin
                failures++;
                $display("FAIL stall_hold_x: got %h required %h", obs_x, exp_x);
            end
        end
        checks++;
        if (hc_s !== 12'd31 || vc_s !== 12'd20 || fs_s !== 1'b0) begin
            failures++;
            $display("FAIL stall_frozen: got (%0d,%0d) fs=%b required (31,20) fs=0", hc_s, vc_s, fs_s);
        end
        advance(1'b1);
        checks++;
        if (hc_s !== 12'd0 || vc_s !== 12'd0 || fs_s !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_wrap: got (%0d,%0d) fs=%b required (0,0) fs=1", hc_s, vc_s, fs_s);
        end
        for (int i = 0; i < 3; i++) begin
            advance(1'b0);
            checks++;
            if (fs_s !== 1'b1 || obs_s !== exp_s) begin
                failures++;
                $display("FAIL stall_pulse_hold: got %h required %h", obs_s, exp_s);
            end
        end
        advance(1'b1);
        checks++;
        if (fs_s !== 1'b0 || hc_s !== 12'd1 || vc_s !== 12'd0) begin
            failures++;
            $display("FAIL stall_no_extra_pulse: got h=%0d v=%0d fs=%b required 1 0 0", hc_s, vc_s, fs_s);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (!(ms_h == 12'd10 && ms_v == 12'd8) && n < 1000) begin
            advance(1'b1);
            n++;
        end
        checks++;
        if (n >= 1000 || obs_s !== exp_s) begin
            failures++;
            $display("FAIL areset_approach: got %h required %h", obs_s, exp_s);
        end
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        mx_h = 12'd0; mx_v = 12'd0; mx_f = 1'b0;
        ms_h = 12'd0; ms_v = 12'd0; ms_f = 1'b0;
        q_x.push_back(xga_exp(mx_h, mx_v, mx_f));
        q_s.push_back(sml_exp(ms_h, ms_v, ms_f));
        #1;
        exp_x = q_x.pop_front();
        exp_s = q_s.pop_front();
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL areset_immediate_s: got %h required %h", obs_s, exp_s);
        end
        checks++;
        if (obs_x !== exp_x) begin
            failures++;
            $display("FAIL areset_immediate_x: got %h required %h", obs_x, exp_x);
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (hc_s !== 12'd0 || vc_s !== 12'd0 || hc_x !== 12'd0 || vc_x !== 12'd0) begin
            failures++;
            $display("FAIL areset_held: got s=(%0d,%0d) x=(%0d,%0d) required zeros", hc_s, vc_s, hc_x, vc_x);
        end
        rst_n = 1'b1;
        advance(1'b1);
        checks++;
        if (hc_s !== 12'd1 || vc_s !== 12'd0 || fs_s !== 1'b0 || obs_s !== exp_s) begin
            failures++;
            $display("FAIL areset_resume_s: got %h required %h", obs_s, exp_s);
        end
        checks++;
        if (obs_x !== exp_x) begin
            failures++;
            $display("FAIL areset_resume_x: got %h required %h", obs_x, exp_x);
        end
    endtask

    initial begin
        test_reset();
        test_hline();
        test_vertical();
        test_frame_wrap();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
